// File: rtl/muldiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : muldiv_unit                                                |
// | Description : Iterative RV32M multiply/divide sequencer with sign fixup. |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] result
);

  localparam int              c_CNT_W = $clog2(XLEN);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0] c_MIN   = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_CALC = 2'd1;
  localparam logic [1:0] c_FIX  = 2'd2;
  localparam logic [1:0] c_DONE = 2'd3;

  logic [1:0]        r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [2:0]        r_funct3;
  logic              r_neg;
  logic              r_sign_a;
  logic [XLEN-1:0]   r_opb;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_result;

  // Accept-time operand decode
  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_sa;
  logic            w_sb;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic            w_div_zero;
  logic            w_ovf;
  logic            w_fast;
  logic [XLEN-1:0] w_fast_result;

  assign w_a_signed = funct3[2] ? ~funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
  assign w_b_signed = funct3[2] ? ~funct3[0] : (funct3[1:0] == 2'b01);
  assign w_sa       = w_a_signed & operand_a[XLEN-1];
  assign w_sb       = w_b_signed & operand_b[XLEN-1];
  assign w_mag_a    = w_sa ? -operand_a : operand_a;
  assign w_mag_b    = w_sb ? -operand_b : operand_b;
  assign w_div_zero = (operand_b == '0);
  assign w_ovf      = ~funct3[0] & (operand_a == c_MIN) & (operand_b == '1);
  assign w_fast     = funct3[2] & (w_div_zero | w_ovf);

  always_comb begin
    w_fast_result = '0;
    if (w_div_zero)
      w_fast_result = funct3[1] ? operand_a : '1;
    else
      w_fast_result = funct3[1] ? '0 : operand_a;
  end

  // Multiply step: r_acc = {partial high, remaining multiplier bits}
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next;

  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, (r_acc[0] ? r_opb : {XLEN{1'b0}})};
  assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

  // Restoring divide step: r_acc = {partial remainder, dividend/quotient}
  logic [XLEN:0]     w_shift;
  logic [XLEN:0]     w_diff;
  logic              w_fit;
  logic [2*XLEN-1:0] w_div_next;

  assign w_shift    = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_diff     = w_shift - {1'b0, r_opb};
  assign w_fit      = ~w_diff[XLEN];
  assign w_div_next = {(w_fit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0]), r_acc[XLEN-2:0], w_fit};

  // Sign fixup and word select, consumed in FIX
  logic [2*XLEN-1:0] w_fix_prod;
  logic [XLEN-1:0]   w_fix_quo;
  logic [XLEN-1:0]   w_fix_rem;
  logic [XLEN-1:0]   w_sel_result;

  assign w_fix_prod = r_neg ? -r_acc : r_acc;
  assign w_fix_quo  = r_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_fix_rem  = r_sign_a ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_sel_result = '0;
    case (r_funct3)
      3'b000:                 w_sel_result = w_fix_prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_sel_result = w_fix_prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_sel_result = w_fix_quo;
      default:                w_sel_result = w_fix_rem;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= c_IDLE;
      r_cnt    <= '0;
      r_funct3 <= '0;
      r_neg    <= 1'b0;
      r_sign_a <= 1'b0;
      r_opb    <= '0;
      r_acc    <= '0;
      r_result <= '0;
    end else if (flush) begin
      r_state <= c_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (req_valid) begin
            r_funct3 <= funct3;
            if (w_fast) begin
              r_result <= w_fast_result;
              r_state  <= c_DONE;
            end else begin
              r_neg    <= w_sa ^ w_sb;
              r_sign_a <= w_sa;
              r_opb    <= w_mag_b;
              r_acc    <= {{XLEN{1'b0}}, w_mag_a};
              r_cnt    <= '0;
              r_state  <= c_CALC;
            end
          end
        end
        c_CALC: begin
          r_acc <= r_funct3[2] ? w_div_next : w_mul_next;
          if (r_cnt == c_LAST) begin
            r_cnt   <= '0;
            r_state <= c_FIX;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        c_FIX: begin
          r_result <= w_sel_result;
          r_state  <= c_DONE;
        end
        default: begin
          if (resp_ready)
            r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = (r_state == c_IDLE);
  assign resp_valid = (r_state == c_DONE);
  assign result     = r_result;

endmodule
`default_nettype wire
